stage3_kernel_sched: RTL and testbench

// - Sequencer for the stage-3 CNN kernel (pool_CI-channel multiply + channel-sum, 2-cycle latency).
// - For each of NUM_OUT output neurons: streams NUM_POS pooled-feature words from the pooling buffer
//   and matching weights from the weight ROM into the kernel, accumulates the NUM_POS kernel sums,
//   and hands out one signed result per neuron over a valid/ready handshake.

---
 rtl/stage3_kernel_sched_if.sv | 38 +++
 rtl/stage3_kernel_sched.sv | 145 ++++++++++++++
 tb/tb_stage3_kernel_sched.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/stage3_kernel_sched_if.sv
// rtl/stage3_kernel_sched_if.sv - control, feature/weight fetch, kernel return and result stream bundle
interface stage3_kernel_sched_if #(
  parameter int NUM_POS = 16,
  parameter int NUM_OUT = 10,
  parameter int KER_BW  = 19,
  parameter int ACC_BW  = 24
);
  localparam int FA_BW  = $clog2(NUM_POS);
  localparam int WA_BW  = $clog2(NUM_POS * NUM_OUT);
  localparam int IDX_BW = $clog2(NUM_OUT);

  logic              i_start;
  logic              o_busy;
  logic              o_done;
  logic              o_fm_rd;
  logic [FA_BW-1:0]  o_fm_addr;
  logic [WA_BW-1:0]  o_w_addr;
  logic              o_pool_valid;
  logic              i_kernel_valid;
  logic [KER_BW-1:0] i_kernel;
  logic              o_result_valid;
  logic              i_result_ready;
  logic [ACC_BW-1:0] o_result;
  logic [IDX_BW-1:0] o_result_idx;
  logic              o_err;

  modport master (
    input  i_start, i_kernel_valid, i_kernel, i_result_ready,
    output o_busy, o_done, o_fm_rd, o_fm_addr, o_w_addr, o_pool_valid,
           o_result_valid, o_result, o_result_idx, o_err
  );

  modport slave (
    output i_start, i_kernel_valid, i_kernel, i_result_ready,
    input  o_busy, o_done, o_fm_rd, o_fm_addr, o_w_addr, o_pool_valid,
           o_result_valid, o_result, o_result_idx, o_err
  );
endinterface

// File: rtl/stage3_kernel_sched.sv
// rtl/stage3_kernel_sched.sv - stage-3 kernel sequencer: per-neuron fetch, accumulate, emit
// Optional STAGE3_SCHED_RELU_EN clamps negative neuron sums to zero when the result is loaded.
module stage3_kernel_sched #(
  parameter int NUM_POS = 16,
  parameter int NUM_OUT = 10,
  parameter int KER_BW  = 19,
  parameter int ACC_BW  = 24
) (
  input  logic clk,
  input  logic reset,
  stage3_kernel_sched_if.master bus
);
  localparam int FA_BW  = $clog2(NUM_POS);
  localparam int WA_BW  = $clog2(NUM_POS * NUM_OUT);
  localparam int IDX_BW = $clog2(NUM_OUT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] EMIT  = 2'd3;

  localparam logic [FA_BW:0]    RET_FULL = (FA_BW + 1)'(NUM_POS);
  localparam logic [FA_BW-1:0]  LAST_POS = FA_BW'(NUM_POS - 1);
  localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(NUM_OUT - 1);

  logic [1:0]        state;
  logic [FA_BW-1:0]  pos;
  logic [IDX_BW-1:0] out_idx;
  logic [FA_BW:0]    ret_cnt;
  logic [ACC_BW-1:0] acc;
  logic              pool_valid;
  logic              busy;
  logic              done;
  logic              err;
  logic              result_valid;
  logic [ACC_BW-1:0] result;
  logic [IDX_BW-1:0] result_idx;

  logic              beat_ok;
  logic              beat_bad;
  logic              start_ok;
  logic              handshake;
  logic [ACC_BW-1:0] acc_nxt;
  logic [FA_BW:0]    ret_nxt;
  logic [ACC_BW-1:0] res_load;

  always_comb begin
    // Beats are only summed while a neuron is in flight and still owed returns.
    beat_ok   = bus.i_kernel_valid && (state == ISSUE || state == DRAIN) && (ret_cnt < RET_FULL);
    beat_bad  = bus.i_kernel_valid && !beat_ok;
    start_ok  = bus.i_start && (state == IDLE) && !busy;
    handshake = (state == EMIT) && result_valid && bus.i_result_ready;
    acc_nxt   = acc;
    ret_nxt   = ret_cnt;
    if (beat_ok) begin
      acc_nxt = acc + {{(ACC_BW - KER_BW){bus.i_kernel[KER_BW-1]}}, bus.i_kernel};
      ret_nxt = ret_cnt + 1'b1;
    end
`ifdef STAGE3_SCHED_RELU_EN
    res_load = acc_nxt[ACC_BW-1] ? '0 : acc_nxt;
`else
    res_load = acc_nxt;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pos          <= '0;
      out_idx      <= '0;
      ret_cnt      <= '0;
      acc          <= '0;
      pool_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      result_idx   <= '0;
    end else begin
      done       <= 1'b0;
      pool_valid <= (state == ISSUE);
      acc        <= acc_nxt;
      ret_cnt    <= ret_nxt;
      if (beat_bad) err <= 1'b1;
      if (done) busy <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state   <= ISSUE;
            busy    <= 1'b1;
            err     <= 1'b0;
            acc     <= '0;
            ret_cnt <= '0;
            out_idx <= '0;
            pos     <= '0;
          end
        end
        ISSUE: begin
          if (pos == LAST_POS) begin
            pos   <= '0;
            state <= DRAIN;
          end else begin
            pos <= pos + 1'b1;
          end
        end
        DRAIN: begin
          // Loading on the edge of the final beat makes the result visible one cycle earlier.
          if (ret_nxt == RET_FULL) begin
            state        <= EMIT;
            result_valid <= 1'b1;
            result       <= res_load;
            result_idx   <= out_idx;
          end
        end
        default: begin
          if (handshake) begin
            result_valid <= 1'b0;
            acc          <= '0;
            ret_cnt      <= '0;
            pos          <= '0;
            if (out_idx == LAST_IDX) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              out_idx <= out_idx + 1'b1;
              state   <= ISSUE;
            end
          end
        end
      endcase
    end
  end

  assign bus.o_busy         = busy;
  assign bus.o_done         = done;
  assign bus.o_fm_rd        = (state == ISSUE);
  assign bus.o_fm_addr      = pos;
  assign bus.o_w_addr       = WA_BW'(out_idx) * WA_BW'(NUM_POS) + WA_BW'(pos);
  assign bus.o_pool_valid   = pool_valid;
  assign bus.o_result_valid = result_valid;
  assign bus.o_result       = result;
  assign bus.o_result_idx   = result_idx;
  assign bus.o_err          = err;
endmodule

// File: tb/tb_stage3_kernel_sched.sv
// tb/tb_stage3_kernel_sched.sv - self-checking bench for stage3_kernel_sched with feature/weight/kernel models
module tb_stage3_kernel_sched;
  localparam int NUM_POS = 16;
  localparam int NUM_OUT = 10;
  localparam int KER_BW  = 19;
  localparam int ACC_BW  = 24;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  int fm[NUM_POS];
  int wt[NUM_POS*NUM_OUT];
  bit kconst_en = 1'b0;
  int kconst = 0;
  logic inj_v = 1'b0;
  logic [KER_BW-1:0] inj_d = '0;
  int fm_q, w_q, k1_d, k2_d;
  logic k1_v, k2_v;

  stage3_kernel_sched_if #(.NUM_POS(NUM_POS), .NUM_OUT(NUM_OUT), .KER_BW(KER_BW), .ACC_BW(ACC_BW)) bus();

  stage3_kernel_sched #(.NUM_POS(NUM_POS), .NUM_OUT(NUM_OUT), .KER_BW(KER_BW), .ACC_BW(ACC_BW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Feature buffer and weight ROM, one-cycle read latency.
  always @(posedge clk) begin
    fm_q <= fm[int'(bus.o_fm_addr)];
    w_q  <= wt[int'(bus.o_w_addr) % (NUM_POS*NUM_OUT)];
  end

  // Kernel: three identical channels multiplied and summed, two-cycle latency.
  always @(posedge clk) begin
    if (reset) begin
      k1_v <= 1'b0; k2_v <= 1'b0; k1_d <= 0; k2_d <= 0;
    end else begin
      k1_v <= bus.o_pool_valid;
      k1_d <= kconst_en ? kconst : 3 * fm_q * w_q;
      k2_v <= k1_v;
      k2_d <= k1_d;
    end
  end

  assign bus.i_kernel_valid = k2_v | inj_v;
  assign bus.i_kernel       = inj_v ? inj_d : k2_d[KER_BW-1:0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ACC_BW-1:0] exp_res(input int n);
    longint s = 0;
    for (int p = 0; p < NUM_POS; p++)
      s += kconst_en ? kconst : 3 * fm[p] * wt[n*NUM_POS + p];
`ifdef STAGE3_SCHED_RELU_EN
    if (s < 0) s = 0;
`endif
    return s[ACC_BW-1:0];
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, ".busy"}, bus.o_busy, 0);
    chk({tag, ".done"}, bus.o_done, 0);
    chk({tag, ".fm_rd"}, bus.o_fm_rd, 0);
    chk({tag, ".fm_addr"}, bus.o_fm_addr, 0);
    chk({tag, ".w_addr"}, bus.o_w_addr, 0);
    chk({tag, ".pool_valid"}, bus.o_pool_valid, 0);
    chk({tag, ".res_valid"}, bus.o_result_valid, 0);
    chk({tag, ".result"}, bus.o_result, 0);
    chk({tag, ".res_idx"}, bus.o_result_idx, 0);
    chk({tag, ".err"}, bus.o_err, 0);
  endtask

  task automatic randomize_mem();
    for (int p = 0; p < NUM_POS; p++) fm[p] = int'($urandom_range(0, 510)) - 255;
    for (int a = 0; a < NUM_POS*NUM_OUT; a++) wt[a] = int'($urandom_range(0, 510)) - 255;
  endtask

  task automatic run_frame(input int stall_idx, input int stall_len, input string tag);
    int rd_n = 0;
    int acc_n = 0;
    int stall_left = stall_len;
    int k = 0;
    int first_v = -1;
    bit done_seen = 1'b0;
    logic [ACC_BW-1:0] held_r = '0;
    logic [3:0] held_i = '0;
    bus.i_result_ready = 1'b1;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk({tag, ".busy"}, bus.o_busy, 1);
    chk({tag, ".err_clr"}, bus.o_err, 0);
    while (!done_seen && k < 1000) begin
      bus.i_start = (k == 37);
      if (bus.o_fm_rd) begin
        chk({tag, ".fm_addr"}, bus.o_fm_addr, rd_n % NUM_POS);
        chk({tag, ".w_addr"}, bus.o_w_addr, rd_n);
        chk({tag, ".no_overlap"}, rd_n / NUM_POS, acc_n);
        rd_n++;
      end
      if (bus.o_result_valid) begin
        if (first_v < 0) first_v = k;
        if (int'(bus.o_result_idx) == stall_idx && stall_left > 0) begin
          if (stall_left == stall_len) begin
            held_r = bus.o_result;
            held_i = bus.o_result_idx;
          end else begin
            chk({tag, ".stall_res"}, bus.o_result, held_r);
            chk({tag, ".stall_idx"}, bus.o_result_idx, held_i);
            chk({tag, ".stall_fm_rd"}, bus.o_fm_rd, 0);
          end
          bus.i_result_ready = 1'b0;
          stall_left--;
        end else begin
          bus.i_result_ready = 1'b1;
          chk({tag, ".result"}, bus.o_result, exp_res(acc_n));
          chk({tag, ".res_idx"}, bus.o_result_idx, acc_n);
          acc_n++;
        end
      end else begin
        bus.i_result_ready = 1'b1;
      end
      if (bus.o_done) begin
        done_seen = 1'b1;
        chk({tag, ".done_after_all"}, acc_n, NUM_OUT);
        chk({tag, ".busy_at_done"}, bus.o_busy, 1);
      end else begin
        tick();
        k++;
      end
    end
    bus.i_start = 1'b0;
    chk({tag, ".done_seen"}, done_seen, 1);
    chk({tag, ".first_latency"}, first_v, NUM_POS + 3);
    chk({tag, ".frame_len"}, k, NUM_OUT*(NUM_POS+4) + stall_len);
    chk({tag, ".reads"}, rd_n, NUM_POS*NUM_OUT);
    tick();
    chk({tag, ".busy_after"}, bus.o_busy, 0);
    chk({tag, ".done_pulse"}, bus.o_done, 0);
  endtask

  initial begin
    int w;
    bus.i_start = 1'b0;
    bus.i_result_ready = 1'b1;
    for (int p = 0; p < NUM_POS; p++) fm[p] = 1;
    for (int a = 0; a < NUM_POS*NUM_OUT; a++) wt[a] = 1;

    reset = 1'b1;
    repeat (3) tick();
    check_zero("rst");
    reset = 1'b0;
    tick();

    // Abort mid-ISSUE of neuron 1.
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (25) tick();
    chk("mid.fm_rd", bus.o_fm_rd, 1);
    reset = 1'b1;
    repeat (2) tick();
    check_zero("midrst");
    reset = 1'b0;
    tick();
    check_zero("postrst");

    run_frame(-1, 0, "ones");

    randomize_mem();
    inj_v = 1'b1;
    inj_d = KER_BW'(77);
    tick();
    inj_v = 1'b0;
    chk("idle_err", bus.o_err, 1);
    run_frame(3, 5, "bp");

    randomize_mem();
    run_frame(-1, 0, "rnd");

    kconst_en = 1'b1;
    kconst = -5;
    run_frame(-1, 0, "neg");
    kconst_en = 1'b0;

    // Stray beat and start while a result is held.
    randomize_mem();
    bus.i_result_ready = 1'b0;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    w = 0;
    while (!bus.o_result_valid && w < 100) begin
      tick();
      w++;
    end
    chk("emit.reach", bus.o_result_valid, 1);
    inj_v = 1'b1;
    inj_d = KER_BW'(1000);
    tick();
    inj_v = 1'b0;
    chk("emit.err", bus.o_err, 1);
    chk("emit.result", bus.o_result, exp_res(0));
    chk("emit.idx", bus.o_result_idx, 0);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    tick();
    chk("busy_start.valid", bus.o_result_valid, 1);
    chk("busy_start.busy", bus.o_busy, 1);
    chk("busy_start.fm_rd", bus.o_fm_rd, 0);
    chk("busy_start.result", bus.o_result, exp_res(0));
    reset = 1'b1;
    repeat (2) tick();
    check_zero("emitrst");
    reset = 1'b0;
    bus.i_result_ready = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
